// File: rtl/tx_byte_queue_if.sv
// tx_byte_queue_if: producer and TX_CONTROLLER-facing signals of tx_byte_queue.
//   wr_en, wr_data           producer push strobe and byte
//   full, empty, count       FIFO status (count excludes the byte held in tx_Din)
//   overflow                 rejected-push indicator
//   tx_send_en, tx_Din       request and byte towards TX_CONTROLLER
//   tx_busy                  TX_CONTROLLER busy flag
// Modports: slave = the queue itself, master = producer/controller side.
interface tx_byte_queue_if #(
    parameter int unsigned ADDR_W = 3
);
    logic              wr_en;
    logic [7:0]        wr_data;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              tx_send_en;
    logic [7:0]        tx_Din;
    logic              tx_busy;

    modport slave (
        input  wr_en, wr_data, tx_busy,
        output full, empty, count, overflow, tx_send_en, tx_Din
    );

    modport master (
        output wr_en, wr_data, tx_busy,
        input  full, empty, count, overflow, tx_send_en, tx_Din
    );
endinterface

// File: rtl/tx_byte_queue.sv
// tx_byte_queue: byte FIFO plus request sequencer in front of TX_CONTROLLER.
// Bytes pushed at clock rate are stored, then handed over one at a time on
// tx_Din/tx_send_en, pacing on tx_busy with GAP_CYCLES idle clocks per frame.
// Ports:
//   CLK_50M   system clock, rising edge
//   reset_n   asynchronous active-low reset
//   bus       tx_byte_queue_if.slave (push side, status, TX_CONTROLLER side)
// Parameters: ADDR_W (depth = 2^ADDR_W), GAP_CYCLES (0..255).
// Optional: define TX_QUEUE_OVF_STICKY_EN to make overflow sticky until reset;
// otherwise overflow pulses for one clock after each rejected push.
module tx_byte_queue #(
    parameter int unsigned ADDR_W     = 3,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic           CLK_50M,
    input  logic           reset_n,
    tx_byte_queue_if.slave bus
);
    localparam int unsigned      Depth   = 1 << ADDR_W;
    localparam logic [ADDR_W:0]  CntFull = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]  CntOne  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PtrOne = ADDR_W'(1);
    localparam logic [7:0]       GapLoad = 8'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StReq, StSend, StGap} state_e;

    state_e              state_q, state_d;
    logic [7:0]          gap_q, gap_d;
    logic [7:0]          mem_q [Depth];
    logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]     count_q;
    logic [7:0]          din_q;
    logic                ovf_q, ovf_d;

    logic full, empty, push, pop, reject;

    assign full   = (count_q == CntFull);
    assign empty  = (count_q == '0);
    // Full is judged on the registered count, so a same-cycle pop cannot admit a push.
    assign push   = bus.wr_en && !full;
    assign reject = bus.wr_en && full;

    // FSM state register
    always_ff @(posedge CLK_50M or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            gap_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
        end
    end

    // FSM next state; the pop happens on the IDLE->REQ edge
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    state_d = StReq;
                    pop     = 1'b1;
                end
            end
            StReq: begin
                if (bus.tx_busy) state_d = StSend;
            end
            StSend: begin
                if (!bus.tx_busy) begin
                    if (GAP_CYCLES == 0) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StGap;
                        gap_d   = GapLoad;
                    end
                end
            end
            StGap: begin
                if (gap_q == 8'd0) state_d = StIdle;
                else               gap_d   = gap_q - 8'd1;
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef TX_QUEUE_OVF_STICKY_EN
    assign ovf_d = ovf_q | reject;
`else
    assign ovf_d = reject;
`endif

    // Queue bookkeeping and the held output byte
    always_ff @(posedge CLK_50M or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            din_q    <= 8'h00;
            ovf_q    <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
                din_q    <= mem_q[rd_ptr_q];
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CntOne;
                2'b01:   count_q <= count_q - CntOne;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: stale entries are never read while count is zero.
    always_ff @(posedge CLK_50M) begin
        if (push) mem_q[wr_ptr_q] <= bus.wr_data;
    end

    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.count      = count_q;
    assign bus.overflow   = ovf_q;
    assign bus.tx_send_en = (state_q == StReq);
    assign bus.tx_Din     = din_q;
endmodule

// File: doc/tx_byte_queue.md
# tx_byte_queue

Byte queue and request sequencer in front of `TX_CONTROLLER`. It accepts bytes from a producer at clock rate and stores them in a FIFO. It then presents them one at a time on `TX_CONTROLLER`'s `Din`/`send_en`, pacing itself on `busy`, so the producer never has to track serial-frame timing. The block sits directly upstream of `TX_CONTROLLER` and shares its clock and reset.

## Interface
- `ADDR_W`, 3, FIFO address width; depth = 2^ADDR_W entries (range 1..8).
- `GAP_CYCLES`, 2, idle clocks forced after `tx_busy` falls before the next request (range 0..255).
- `CLK_50M`  in  1  system clock, 50 MHz, rising edge.
- `reset_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `wr_en`  in  1  push `wr_data` this cycle.
- `wr_data`  in  8  byte to enqueue.
- `full`  out  1  FIFO holds 2^ADDR_W bytes.
- `empty`  out  1  FIFO holds 0 bytes.
- `count`  out  ADDR_W+1  bytes currently stored; excludes the byte held in `tx_Din`.
- `overflow`  out  1  a push was rejected (behaviour per Configuration).
- `tx_send_en`  out  1  to `TX_CONTROLLER.send_en`.
- `tx_Din`  out  8  to `TX_CONTROLLER.Din`; stable for the whole of REQ and SEND.
- `tx_busy`  in  1  from `TX_CONTROLLER.busy`.

## Operation
- Storage: register array; `wr_ptr`/`rd_ptr` are ADDR_W bits and wrap modulo depth.
  - `count` is tracked separately, so full (`count == 2^ADDR_W`) and empty (`count == 0`) are unambiguous.
- Push is accepted when `wr_en && !full`. It writes `mem[wr_ptr]` and increments `wr_ptr`.
- Push with `wr_en && full` is dropped; pointers are unchanged and `overflow` is raised.
- A push while full is rejected even if a pop occurs in the same cycle.
- A simultaneous accepted push and pop leaves `count` unchanged.
- The FSM has four states: IDLE, REQ, SEND, GAP.
  - IDLE → REQ when `!empty`. On this edge: `tx_Din <= mem[rd_ptr]`, `rd_ptr++`, `count--` (pop).
  - REQ → SEND on the first cycle `tx_busy == 1`.
  - SEND → GAP when `tx_busy == 0`, or → IDLE directly if `GAP_CYCLES == 0`.
  - GAP: an 8-bit counter loads `GAP_CYCLES-1` on entry and decrements; GAP → IDLE when it reads 0.
- `tx_send_en` = (state == REQ), decoded from the state register only. It stays high until `busy` is seen, with no timeout.
- `tx_Din` changes only on the IDLE→REQ pop.
- `tx_busy` is ignored in IDLE and GAP.
- A `tx_busy` already high on entry to REQ moves to SEND after one cycle, with `tx_send_en` high for exactly one clock.
- Asynchronous reset mid-operation takes effect immediately:
  - state → IDLE, `tx_send_en` → 0, pointers/`count` → 0;
  - queued bytes are discarded;
  - the byte in `tx_Din` is abandoned.

## Timing
- Reset values:
  - `full` = 0, `empty` = 1, `count` = 0, `overflow` = 0;
  - `tx_send_en` = 0, `tx_Din` = 8'h00;
  - state = IDLE, gap counter = 0.
- All outputs are registered or decoded from registers; no combinational path from any input to any output.
- Latency: accepted push into an empty, IDLE block at edge N →
  - `count` = 1 after edge N;
  - pop at edge N+1;
  - `tx_send_en` = 1 after edge N+1.
- `full`, `empty` and `count` update on the edge that accepts the push or pop.
- Inter-byte spacing: `tx_busy` falling seen at edge M →
  - next `tx_send_en` rises after edge M + GAP_CYCLES + 1 (queue non-empty);
  - after edge M + 1 when `GAP_CYCLES == 0`.
- Maximum throughput is one pop per `TX_CONTROLLER` frame. Pushes are allowed every clock until full.

## Configuration
- `TX_QUEUE_OVF_STICKY_EN` defined:
  - `overflow` sets on any rejected push;
  - it stays high until `reset_n` is asserted.
- Not defined:
  - `overflow` is a one-clock pulse in the cycle after each rejected push;
  - back-to-back rejected pushes hold it high continuously.
- Queue and FSM behaviour are identical either way.

## Test plan
- Single byte: reset, push 8'hA5 at edge N.
  - `tx_send_en` = 1 after edge N+1 and `tx_Din` = 8'hA5.
  - With a model asserting `tx_busy` 3 clocks later, `tx_send_en` drops the cycle after `busy` is seen.
  - `count` returns to 0.
- Fill/overflow (ADDR_W=3): hold `tx_busy` = 0 and push 10 bytes 8'h01..8'h0A on consecutive clocks.
  - First byte popped; 8 bytes stored; `full` = 1; the 10th push is dropped and raises `overflow`.
  - Drain with the `busy` model: `tx_Din` sequence is 01..09 in order; 0A never appears.
- Simultaneous push/pop: with `count` = 3 in IDLE, push on the pop cycle → `count` stays 3 and FIFO order is preserved across pointer wrap.
- Gap: GAP_CYCLES=2, two queued bytes → exactly 2 cycles in GAP between `tx_busy` falling and the second `tx_send_en` rise (3 clocks total). With GAP_CYCLES=0 → 1 clock.
- Reset mid-send: assert `reset_n` = 0 asynchronously during SEND with 4 bytes queued.
  - `tx_send_en` = 0, `count` = 0, `empty` = 1 immediately.
  - After release, no request occurs until a new push.
- Macro: overflow twice, then wait 10 clocks.
  - With `TX_QUEUE_OVF_STICKY_EN`, `overflow` is still 1.
  - Without it, two single-clock pulses are seen and `overflow` is 0 at the end.
